// File: rtl/pipe_hold_ctrl_pkg.sv
// rtl/pipe_hold_ctrl_pkg.sv - hold levels, controller state encodings and the hold-priority helper
package pipe_hold_ctrl_pkg;

    localparam int HOLD_FLAG_BUS = 3;
    localparam int PHC_STATE_BUS = 2;

    typedef enum logic [HOLD_FLAG_BUS-1:0] {
        HOLD_NONE = 3'd0,
        HOLD_PC   = 3'd1,
        HOLD_IF   = 3'd2,
        HOLD_ID   = 3'd3
    } hold_e;

    typedef enum logic [PHC_STATE_BUS-1:0] {
        PHC_RUN   = 2'd0,
        PHC_FLUSH = 2'd1,
        PHC_DRAIN = 2'd2,
        PHC_GRANT = 2'd3
    } phc_state_e;

    // Deeper pipeline holds have numerically larger codes, so priority is a plain max.
    function automatic hold_e hold_max(input hold_e a, input hold_e b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pipe_hold_cnt.sv
// rtl/pipe_hold_cnt.sv - loadable down-counter with enable, flags when the count is 1
module pipe_hold_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             one_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign one_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pipe_hold_ctrl.sv
// rtl/pipe_hold_ctrl.sv - pipeline hold/flush/bus-grant controller; PIPE_HOLD_STATS_EN enables stall/flush counters
module pipe_hold_ctrl
    import pipe_hold_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_req_i,
    input  logic [31:0] jump_addr_i,
    input  logic        ex_busy_i,
    input  logic        clint_hold_i,
    input  logic        jtag_halt_i,
    input  logic        bus_req_i,
    output logic        bus_gnt_o,
    output logic        jump_o,
    output logic [31:0] jump_addr_o,
    output logic [2:0]  hold_flag_o,
    output logic [1:0]  state_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);

    phc_state_e  state_q;
    logic        pending_q;
    logic        block_q;
    logic        jump_q;
    logic [31:0] pend_addr_q;
    logic [31:0] jump_addr_q;

    logic        go_flush;
    logic        go_drain;
    logic        cnt_one;
    hold_e       state_hold;
    hold_e       level_hold;

    // Transition decisions are shared by the FSM and the counter load.
    always_comb begin
        go_flush = 1'b0;
        go_drain = 1'b0;
        case (state_q)
            PHC_RUN: begin
                go_flush = jump_req_i;
                go_drain = !jump_req_i && bus_req_i && !block_q;
            end
            PHC_FLUSH: begin
                go_flush = jump_req_i;
                go_drain = !jump_req_i && cnt_one && bus_req_i;
            end
            PHC_DRAIN: go_flush = jump_req_i;
            PHC_GRANT: go_flush = !bus_req_i && (pending_q || jump_req_i);
            default: ;
        endcase
    end

    pipe_hold_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (go_flush || go_drain),
        .load_val_i (go_flush ? CNT_W'(FLUSH_CYCLES) : CNT_W'(DRAIN_CYCLES)),
        .en_i       ((state_q == PHC_FLUSH) || ((state_q == PHC_DRAIN) && !ex_busy_i)),
        .one_o      (cnt_one)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PHC_RUN;
            pending_q   <= 1'b0;
            block_q     <= 1'b0;
            jump_q      <= 1'b0;
            pend_addr_q <= '0;
            jump_addr_q <= '0;
        end else begin
            jump_q  <= go_flush;
            block_q <= 1'b0;
            if (go_flush) begin
                jump_addr_q <= (state_q == PHC_GRANT && !jump_req_i) ? pend_addr_q : jump_addr_i;
                state_q     <= PHC_FLUSH;
            end
            case (state_q)
                PHC_RUN: begin
                    if (go_drain) state_q <= PHC_DRAIN;
                end
                PHC_FLUSH: begin
                    if (!go_flush && cnt_one) state_q <= go_drain ? PHC_DRAIN : PHC_RUN;
                end
                PHC_DRAIN: begin
                    if (!go_flush) begin
                        if (!bus_req_i)                    state_q <= PHC_RUN;
                        else if (!ex_busy_i && cnt_one)    state_q <= PHC_GRANT;
                    end
                end
                PHC_GRANT: begin
                    if (!bus_req_i) begin
                        pending_q <= 1'b0;
                        if (!go_flush) begin
                            state_q <= PHC_RUN;
                            block_q <= 1'b1;
                        end
                    end else if (jump_req_i) begin
                        pending_q   <= 1'b1;
                        pend_addr_q <= jump_addr_i;
                    end
                end
                default: state_q <= PHC_RUN;
            endcase
        end
    end

    always_comb begin
        case (state_q)
            PHC_FLUSH:            state_hold = HOLD_ID;
            PHC_DRAIN, PHC_GRANT: state_hold = HOLD_PC;
            default:              state_hold = HOLD_NONE;
        endcase
        if (clint_hold_i)                   level_hold = HOLD_ID;
        else if (ex_busy_i || jtag_halt_i)  level_hold = HOLD_PC;
        else                                level_hold = HOLD_NONE;
        hold_flag_o = rst ? HOLD_NONE : hold_max(state_hold, level_hold);
    end

    assign bus_gnt_o   = (state_q == PHC_GRANT);
    assign jump_o      = jump_q;
    assign jump_addr_o = jump_addr_q;
    assign state_o     = state_q;

`ifdef PIPE_HOLD_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((hold_flag_o != 3'd0) && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (jump_q && (flush_cnt_q != 32'hFFFF_FFFF))                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// tb/tb_pipe_hold_ctrl.sv - directed and randomized checks of pipe_hold_ctrl against a rule-level model
module tb_pipe_hold_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_req, ex_busy, clint_hold, jtag_halt, bus_req;
    logic [31:0] jump_addr;
    logic        bus_gnt, jump_o;
    logic [31:0] jump_addr_o, stall_cnt, flush_cnt;
    logic [2:0]  hold_flag;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    localparam int F = 2;
    localparam int D = 2;
`ifdef PIPE_HOLD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    always #5 clk = ~clk;

    pipe_hold_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .jump_req_i   (jump_req),
        .jump_addr_i  (jump_addr),
        .ex_busy_i    (ex_busy),
        .clint_hold_i (clint_hold),
        .jtag_halt_i  (jtag_halt),
        .bus_req_i    (bus_req),
        .bus_gnt_o    (bus_gnt),
        .jump_o       (jump_o),
        .jump_addr_o  (jump_addr_o),
        .hold_flag_o  (hold_flag),
        .state_o      (state),
        .stall_cnt_o  (stall_cnt),
        .flush_cnt_o  (flush_cnt)
    );

    // Reference model: 0=RUN 1=FLUSH 2=DRAIN 3=GRANT, m_left = cycles remaining in the timed phase
    int          m_state, m_left;
    bit          m_pend, m_block, m_jump;
    logic [31:0] m_paddr, m_jaddr, m_stall, m_flush;

    function automatic int exp_hold();
        int s, l;
        if (rst) return 0;
        s = (m_state == 1) ? 3 : (m_state >= 2) ? 1 : 0;
        l = clint_hold ? 3 : (ex_busy || jtag_halt) ? 1 : 0;
        return (s > l) ? s : l;
    endfunction

    task automatic model_reset();
        m_state = 0; m_left = 0; m_pend = 0; m_block = 0; m_jump = 0;
        m_paddr = 0; m_jaddr = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic enter_flush(input logic [31:0] a);
        m_state = 1; m_left = F; m_jump = 1'b1; m_jaddr = a;
    endtask

    task automatic model_step();
        int h;
        bit j_now, nb;
        h = exp_hold();
        j_now = m_jump;
        m_jump = 1'b0;
        nb = 1'b0;
        case (m_state)
            0: if (jump_req) enter_flush(jump_addr);
               else if (bus_req && !m_block) begin m_state = 2; m_left = D; end
            1: if (jump_req) enter_flush(jump_addr);
               else if (m_left == 1) begin
                   if (bus_req) begin m_state = 2; m_left = D; end
                   else m_state = 0;
               end else m_left--;
            2: if (jump_req) enter_flush(jump_addr);
               else if (!bus_req) m_state = 0;
               else if (!ex_busy) begin
                   if (m_left == 1) m_state = 3; else m_left--;
               end
            default: if (!bus_req) begin
                   if (m_pend || jump_req) enter_flush(jump_req ? jump_addr : m_paddr);
                   else begin m_state = 0; nb = 1'b1; end
                   m_pend = 1'b0;
               end else if (jump_req) begin m_pend = 1'b1; m_paddr = jump_addr; end
        endcase
        m_block = nb;
        if (h != 0 && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (j_now && m_flush != 32'hFFFF_FFFF) m_flush++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("hold_flag", 32'(hold_flag), exp_hold());
        chk("bus_gnt", 32'(bus_gnt), 32'(m_state == 3 && !rst));
        chk("state", 32'(state), m_state);
        chk("jump_o", 32'(jump_o), 32'(m_jump));
        chk("jump_addr_o", jump_addr_o, m_jaddr);
        chk("stall_cnt", stall_cnt, STATS ? m_stall : 32'd0);
        chk("flush_cnt", flush_cnt, STATS ? m_flush : 32'd0);
    endtask

    task automatic cyc();
        if (rst) model_reset();
        #1;
        compare_all();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        #1;
    endtask

    initial begin
        rst = 1'b1; jump_req = 0; jump_addr = 0; ex_busy = 0; clint_hold = 0; jtag_halt = 0; bus_req = 0;
        model_reset();
        repeat (2) cyc();
        rst = 1'b0;
        repeat (2) cyc();

        // Jump at N
        jump_req = 1; jump_addr = 32'h100; cyc();
        jump_req = 0; #1;
        chk("jmp_n1_jump_o", 32'(jump_o), 1); chk("jmp_n1_addr", jump_addr_o, 32'h100); chk("jmp_n1_hold", 32'(hold_flag), 3);
        cyc(); #1; chk("jmp_n2_hold", 32'(hold_flag), 3); chk("jmp_n2_jump_o", 32'(jump_o), 0);
        cyc(); #1; chk("jmp_n3_hold", 32'(hold_flag), 0);
        cyc();

        // Bus grant and post-grant fairness cycle
        bus_req = 1; cyc();
        #1; chk("bus_n1_hold", 32'(hold_flag), 1); cyc();
        cyc();
        #1; chk("bus_n3_gnt", 32'(bus_gnt), 1); cyc();
        cyc();
        bus_req = 0; cyc();
        bus_req = 1; #1; chk("bus_n6_gnt", 32'(bus_gnt), 0); chk("bus_n6_hold", 32'(hold_flag), 0); cyc();
        #1; chk("bus_n7_state", 32'(state), 0); cyc();
        #1; chk("bus_n8_state", 32'(state), 2);
        bus_req = 0; cyc();
        cyc();

        // Simultaneous jump and bus request, then jump while granted
        jump_req = 1; jump_addr = 32'h40; bus_req = 1; cyc();
        jump_req = 0; #1; chk("sim_n1_state", 32'(state), 1); cyc();
        #1; chk("sim_n2_state", 32'(state), 1); cyc();
        #1; chk("sim_n3_state", 32'(state), 2); cyc();
        #1; chk("sim_n4_state", 32'(state), 2); cyc();
        #1; chk("sim_n5_gnt", 32'(bus_gnt), 1);
        jump_req = 1; jump_addr = 32'h200; cyc();
        jump_req = 0; #1; chk("gj_no_jump_o", 32'(jump_o), 0); chk("gj_gnt", 32'(bus_gnt), 1); cyc();
        bus_req = 0; cyc();
        #1; chk("gj_jump_o", 32'(jump_o), 1); chk("gj_addr", jump_addr_o, 32'h200); chk("gj_hold1", 32'(hold_flag), 3); cyc();
        #1; chk("gj_hold2", 32'(hold_flag), 3); cyc();
        #1; chk("gj_hold3", 32'(hold_flag), 0); cyc();

        // Reset in GRANT with a pending jump
        bus_req = 1; repeat (3) cyc();
        #1; chk("rg_gnt_before", 32'(bus_gnt), 1);
        jump_req = 1; jump_addr = 32'h300; cyc();
        jump_req = 0; rst = 1; jtag_halt = 1; model_reset(); #1;
        chk("rg_gnt", 32'(bus_gnt), 0); chk("rg_state", 32'(state), 0); chk("rg_hold", 32'(hold_flag), 0);
        repeat (2) cyc();
        rst = 0; jtag_halt = 0; bus_req = 0; cyc();
        #1; chk("rg_no_pending_jump", 32'(jump_o), 0); chk("rg_state_run", 32'(state), 0); cyc();

        // Stall counting
        ex_busy = 1; repeat (10) cyc();
        #1; chk("stall_10", stall_cnt, STATS ? 32'd10 : 32'd0);
`ifdef PIPE_HOLD_STATS_EN
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        m_stall = 32'hFFFF_FFFE;
        repeat (3) cyc();
        #1; chk("stall_sat", stall_cnt, 32'hFFFF_FFFF);
`endif
        ex_busy = 0; cyc();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            jump_req   = ($urandom_range(0, 7) == 0);
            jump_addr  = $urandom;
            ex_busy    = ($urandom_range(0, 3) == 0);
            clint_hold = ($urandom_range(0, 9) == 0);
            jtag_halt  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 9) == 0) bus_req = ~bus_req;
            rst        = ($urandom_range(0, 149) == 0);
            cyc();
        end
        rst = 0; jump_req = 0; ex_busy = 0; clint_hold = 0; jtag_halt = 0; bus_req = 0;
        repeat (4) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
